// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive front end.
package i2c_pkg;

    localparam int FRAME_W     = 12;
    localparam int FR_START    = 0;
    localparam int FR_ACK      = 1;
    localparam int FR_DATA_LSB = 2;
    localparam int FR_NACK     = 10;
    localparam int FR_STOP     = 11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_frame_rx_pin_sync.sv
// SCL/SDA synchroniser, edge pulses and START/STOP detection.
// With I2C_GLITCH_FILTER_EN each pin also passes a 3-sample majority filter.
module i2c_pin_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl_f;
    logic       sda_f;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    assign scl_f = maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
    assign sda_f = maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    assign sda_lvl  = sda_f;
    assign scl_rise = scl_f & ~scl_prev;
    assign scl_fall = ~scl_f & scl_prev;
    // SDA edges only count as bus conditions while SCL is high
    assign start    = ~sda_f & sda_prev & scl_f;
    assign stop     = sda_f & ~sda_prev & scl_f;

endmodule

// File: rtl/i2c_frame_rx.sv
// I2C slave write receiver: address match, ACK generation and 12-bit frame output.
// Optional SCL/SDA glitch filter enabled by I2C_GLITCH_FILTER_EN.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting address + rw bit
// ADDR_ACK | driving address ACK until next SCL fall
// DATA     | shifting a data byte
// DATA_ACK | driving (or withholding) data ACK until next SCL fall
// IGNORE   | not addressed, waiting for START or STOP
module i2c_frame_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h01,
    parameter int         MAX_BYTES = 6,
    parameter int         FRAME_W   = i2c_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               sda_oe,
    output logic [FRAME_W-1:0] frame_o,
    output logic               frame_valid,
    output logic [3:0]         addr_o,
    output logic               busy,
    output logic [2:0]         byte_cnt
);

    localparam logic [2:0] MAX_B = 3'(MAX_BYTES);

    logic sda_lvl, scl_rise, scl_fall, start, stop;

    i2c_pin_sync u_pin_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_lvl  (sda_lvl),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t             state, state_d;
    logic [7:0]         shift, shift_d;
    logic [3:0]         bit_cnt, bit_cnt_d;
    logic               ack_flag, ack_flag_d;
    logic               frame_pend, frame_pend_d;
    logic               stop_pend, stop_pend_d;
    logic               sda_oe_d, frame_valid_d, busy_d;
    logic [FRAME_W-1:0] frame_d;
    logic [3:0]         addr_d;
    logic [2:0]         byte_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            ack_flag    <= 1'b0;
            frame_pend  <= 1'b0;
            stop_pend   <= 1'b0;
            sda_oe      <= 1'b0;
            frame_o     <= '0;
            frame_valid <= 1'b0;
            addr_o      <= '0;
            busy        <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            state       <= state_d;
            shift       <= shift_d;
            bit_cnt     <= bit_cnt_d;
            ack_flag    <= ack_flag_d;
            frame_pend  <= frame_pend_d;
            stop_pend   <= stop_pend_d;
            sda_oe      <= sda_oe_d;
            frame_o     <= frame_d;
            frame_valid <= frame_valid_d;
            addr_o      <= addr_d;
            busy        <= busy_d;
            byte_cnt    <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        shift_d       = shift;
        bit_cnt_d     = bit_cnt;
        ack_flag_d    = ack_flag;
        frame_pend_d  = frame_pend;
        stop_pend_d   = stop_pend;
        sda_oe_d      = sda_oe;
        frame_d       = frame_o;
        frame_valid_d = 1'b0;
        addr_d        = addr_o;
        busy_d        = busy;
        byte_cnt_d    = byte_cnt;

        // A pending data frame always goes out before a pending stop frame
        if (frame_pend) begin
            frame_valid_d              = 1'b1;
            frame_pend_d               = 1'b0;
            frame_d                    = '0;
            frame_d[FR_START]          = 1'b1;
            frame_d[FR_ACK]            = ack_flag;
            frame_d[FR_DATA_LSB +: 8]  = shift;
            frame_d[FR_NACK]           = ~ack_flag;
            if (ack_flag && byte_cnt < MAX_B)
                byte_cnt_d = byte_cnt + 3'd1;
        end else if (stop_pend) begin
            frame_valid_d    = 1'b1;
            stop_pend_d      = 1'b0;
            frame_d          = '0;
            frame_d[FR_STOP] = 1'b1;
        end

        if (start) begin
            state_d    = ADDR;
            busy_d     = 1'b1;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            addr_d     = '0;
        end else if (stop) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            addr_d    = '0;
            bit_cnt_d = '0;
            if (state inside {ADDR, ADDR_ACK, DATA, DATA_ACK} &&
                (byte_cnt != 3'd0 || (frame_pend && ack_flag)))
                stop_pend_d = 1'b1;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_d   = {shift[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == DEV_ADDR && !shift[0]) begin
                                sda_oe_d = 1'b1;
                                addr_d   = DEV_ADDR[3:0];
                                state_d  = ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = IGNORE;
                            end
                        end else begin
                            ack_flag_d = (byte_cnt < MAX_B);
                            sda_oe_d   = (byte_cnt < MAX_B);
                            state_d    = DATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = DATA;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d     = 1'b0;
                        frame_pend_d = 1'b1;
                        state_d      = DATA;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_frame_rx.sv
// Directed bench for i2c_frame_rx: bus master model with open-drain SDA and a frame monitor.
module tb_i2c_frame_rx;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_drv;
    logic        sda_drv;
    logic        sda_oe;
    logic [11:0] frame_o;
    logic        frame_valid;
    logic [3:0]  addr_o;
    logic        busy;
    logic [2:0]  byte_cnt;
    logic        sda_wire;

    assign sda_wire = sda_drv & ~sda_oe;

    i2c_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl_drv),
        .sda_i       (sda_wire),
        .sda_oe      (sda_oe),
        .frame_o     (frame_o),
        .frame_valid (frame_valid),
        .addr_o      (addr_o),
        .busy        (busy),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] fq[$];
    logic        fv_prev = 1'b0;
    int          consec = 0;
    int          busy_seen = 0;

    always @(negedge clk) begin
        if (frame_valid) fq.push_back(frame_o);
        if (frame_valid && fv_prev) consec++;
        if (busy) busy_seen++;
        fv_prev <= frame_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    wait_clk(Q);
        scl_drv = 1'b1; wait_clk(2 * Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic ack_slot(output logic ack);
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        ack = sda_oe;   wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot(ack);
    endtask

    logic [11:0] t3_exp [7] = '{12'h007, 12'h00B, 12'h00F, 12'h013, 12'h017, 12'h01B, 12'h41D};
    logic        ack;
    logic [7:0]  b8;

    initial begin
        rst_n = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
        wait_clk(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_frame", frame_o, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr_o, 0);
        check("rst_bcnt", byte_cnt, 0);
        rst_n = 1'b1;
        wait_clk(4);

        // Basic write of one byte
        fq.delete();
        i2c_start();
        check("t1_busy", busy, 1);
        send_byte(8'h02, ack);
        check("t1_addr_ack", ack, 1);
        check("t1_addr_o", addr_o, 4'h1);
        send_byte(8'hCF, ack);
        check("t1_data_ack", ack, 1);
        check("t1_nframes", fq.size(), 1);
        if (fq.size() > 0) check("t1_frame", fq[0], 12'h33F);
        check("t1_bcnt", byte_cnt, 1);
        i2c_stop();
        check("t1_nframes_stop", fq.size(), 2);
        if (fq.size() > 1) check("t1_stop_frame", fq[1], 12'h800);
        check("t1_busy_stop", busy, 0);
        check("t1_addr_stop", addr_o, 0);

        // Address mismatch: nothing acknowledged
        fq.delete();
        i2c_start();
        send_byte(8'h06, ack);
        check("t2_addr_nack", ack, 0);
        check("t2_addr_o", addr_o, 0);
        send_byte(8'h55, ack);
        check("t2_data_nack", ack, 0);
        check("t2_busy", busy, 1);
        i2c_stop();
        check("t2_nframes", fq.size(), 0);
        check("t2_busy_stop", busy, 0);

        // Seven bytes, bank holds six
        fq.delete();
        i2c_start();
        send_byte(8'h02, ack);
        check("t3_addr_ack", ack, 1);
        for (int i = 1; i <= 7; i++) begin
            b8 = 8'(i);
            send_byte(b8, ack);
            check($sformatf("t3_ack%0d", i), ack, (i <= 6) ? 1 : 0);
        end
        check("t3_bcnt", byte_cnt, 6);
        check("t3_nframes", fq.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < fq.size()) check($sformatf("t3_frame%0d", i + 1), fq[i], t3_exp[i]);
        i2c_stop();
        check("t3_nframes_stop", fq.size(), 8);
        if (fq.size() > 7) check("t3_stop_frame", fq[7], 12'h800);

        // Repeated start
        fq.delete();
        i2c_start();
        send_byte(8'h02, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        check("t4_bcnt2", byte_cnt, 2);
        i2c_rstart();
        check("t4_bcnt_rs", byte_cnt, 0);
        check("t4_nframes_rs", fq.size(), 2);
        send_byte(8'h02, ack);
        check("t4_readdr_ack", ack, 1);
        send_byte(8'hAA, ack);
        check("t4_nframes", fq.size(), 3);
        if (fq.size() > 2) check("t4_frame", fq[2], 12'h2AB);
        check("t4_bcnt1", byte_cnt, 1);
        i2c_stop();
        check("t4_nframes_stop", fq.size(), 4);
        if (fq.size() > 3) check("t4_stop_frame", fq[3], 12'h800);

        // Reset in the middle of a data byte
        fq.delete();
        i2c_start();
        send_byte(8'h02, ack);
        b8 = 8'hF0;
        for (int i = 7; i >= 4; i--) send_bit(b8[i]);
        rst_n = 1'b0;
        wait_clk(1);
        check("t5_rst_sda_oe", sda_oe, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_frame", frame_o, 0);
        check("t5_rst_bcnt", byte_cnt, 0);
        check("t5_rst_addr", addr_o, 0);
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(b8[i]);
        ack_slot(ack);
        check("t5_post_ack", ack, 0);
        check("t5_post_busy", busy, 0);
        i2c_stop();
        check("t5_nframes", fq.size(), 0);
        i2c_start();
        send_byte(8'h02, ack);
        check("t5_fresh_ack", ack, 1);
        i2c_stop();
        check("t5_no_stop_frame", fq.size(), 0);
        check("t5_idle_busy", busy, 0);

        // One-clock SDA glitch while SCL high
        wait_clk(Q);
        busy_seen = 0;
        @(negedge clk);
        sda_drv = 1'b0;
        @(negedge clk);
        sda_drv = 1'b1;
        wait_clk(20);
`ifdef I2C_GLITCH_FILTER_EN
        check("t6_glitch_rejected", (busy_seen != 0), 0);
`else
        check("t6_glitch_start", (busy_seen != 0), 1);
`endif
        check("t6_busy_end", busy, 0);
        check("fv_never_consecutive", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
